// File: rtl/mesm6_defines.sv
// Shared encodings for the mesm6 memory arbiter: FSM states, bus owner, default ack timeout.
package mesm6_defines;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } arb_owner_e;

    localparam int ARB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/mesm6_arb_timer.sv
// 8-bit ack-timeout counter; expired_o flags the last allowed wait cycle so the
// caller can leave ACCESS after exactly LIMIT cycles without an ack.
module mesm6_arb_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'd0;
        else if (inc_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == LIMIT - 8'd1);

endmodule

// File: rtl/mesm6_mem_arbiter.sv
// Merges the mesm6 core's ibus and dbus onto one req/ack memory port, dbus first,
// with per-port one-cycle recovery after done, ack timeout and a sticky bus error.
module mesm6_mem_arbiter
    import mesm6_defines::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 48,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ibus_fetch,
    input  logic [ADDR_W-1:0] ibus_addr,
    output logic [DATA_W-1:0] ibus_input,
    output logic              ibus_done,
    input  logic              dbus_read,
    input  logic              dbus_write,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_output,
    output logic [DATA_W-1:0] dbus_input,
    output logic              dbus_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] iin_q, iin_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              rec_i_q, rec_i_d;
    logic              rec_d_q, rec_d_d;
    logic              in_access;
    logic              tmr_expired;
    logic              d_elig, i_elig;

    assign in_access = (state_q == ARB_ACCESS);

    mesm6_arb_timer #(.LIMIT(8'(TIMEOUT))) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (!in_access),
        .inc_i     (in_access && !mem_ack),
        .expired_o (tmr_expired)
    );

    // The core holds its request one cycle past done; mask only the port just served.
    assign d_elig = (dbus_read || dbus_write) && !rec_d_q;
    assign i_elig = ibus_fetch && !rec_i_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        iin_d   = iin_q;
        din_d   = din_q;
        err_d   = err_q;
        rec_i_d = (state_q == ARB_RESP) && (owner_q == OWN_IBUS);
        rec_d_d = (state_q == ARB_RESP) && (owner_q == OWN_DBUS);
        case (state_q)
            ARB_IDLE: begin
                if (d_elig) begin
                    owner_d = OWN_DBUS;
                    addr_d  = dbus_addr;
                    we_d    = dbus_write;
                    wdata_d = dbus_output;
                    if (dbus_read && dbus_write)
                        err_d = 1'b1;
                    state_d = ARB_ACCESS;
                end else if (i_elig) begin
                    owner_d = OWN_IBUS;
                    addr_d  = ibus_addr;
                    we_d    = 1'b0;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (mem_ack || tmr_expired) begin
                    // Timeout returns 0 as read data; writes never touch dbus_input.
                    if (!we_q) begin
                        if (owner_q == OWN_DBUS)
                            din_d = mem_ack ? mem_rdata : '0;
                        else
                            iin_d = mem_ack ? mem_rdata : '0;
                    end
                    if (!mem_ack)
                        err_d = 1'b1;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IBUS;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            iin_q   <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            rec_i_q <= 1'b0;
            rec_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            iin_q   <= iin_d;
            din_q   <= din_d;
            err_q   <= err_d;
            rec_i_q <= rec_i_d;
            rec_d_q <= rec_d_d;
        end
    end

    assign mem_req    = in_access;
    assign mem_we     = we_q && in_access;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign ibus_input = iin_q;
    assign dbus_input = din_q;
    assign ibus_done  = (state_q == ARB_RESP) && (owner_q == OWN_IBUS);
    assign dbus_done  = (state_q == ARB_RESP) && (owner_q == OWN_DBUS);
    assign bus_err    = err_q;

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Directed bench for mesm6_mem_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mesm6_mem_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 48;

    logic              clk = 1'b0;
    logic              reset;
    logic              ibus_fetch;
    logic [ADDR_W-1:0] ibus_addr;
    logic [DATA_W-1:0] ibus_input;
    logic              ibus_done;
    logic              dbus_read;
    logic              dbus_write;
    logic [ADDR_W-1:0] dbus_addr;
    logic [DATA_W-1:0] dbus_output;
    logic [DATA_W-1:0] dbus_input;
    logic              dbus_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              bus_err;

    int n_chk = 0;
    int n_err = 0;
    int n_burst = 0;
    int n_idone = 0;
    int n_ddone = 0;
    int cyc_cnt;
    logic req_prev = 1'b0;

    mesm6_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ibus_fetch  (ibus_fetch),
        .ibus_addr   (ibus_addr),
        .ibus_input  (ibus_input),
        .ibus_done   (ibus_done),
        .dbus_read   (dbus_read),
        .dbus_write  (dbus_write),
        .dbus_addr   (dbus_addr),
        .dbus_output (dbus_output),
        .dbus_input  (dbus_input),
        .dbus_done   (dbus_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && !req_prev) n_burst++;
        if (ibus_done) n_idone++;
        if (dbus_done) n_ddone++;
        req_prev <= mem_req;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ibus_fetch = 0; ibus_addr = '0; dbus_read = 0; dbus_write = 0;
        dbus_addr = '0; dbus_output = '0; mem_rdata = '0; mem_ack = 0;
        tick(); tick();
        chk("rst_req", 64'(mem_req), 0);
        chk("rst_err", 64'(bus_err), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_iin", 64'(ibus_input), 0);
        chk("rst_din", 64'(dbus_input), 0);
        reset = 1'b0;
        tick();

        // 1: fetch with ack in first request cycle
        ibus_fetch = 1; ibus_addr = 15'h0010;
        tick();
        chk("t1_req", 64'(mem_req), 1);
        chk("t1_addr", 64'(mem_addr), 64'h10);
        chk("t1_we", 64'(mem_we), 0);
        mem_ack = 1; mem_rdata = 48'h123456789ABC;
        tick();
        mem_ack = 0; mem_rdata = '0;
        chk("t1_done", 64'(ibus_done), 1);
        chk("t1_req_drop", 64'(mem_req), 0);
        chk("t1_data", 64'(ibus_input), 64'h123456789ABC);
        tick();
        chk("t1_done_once", 64'(ibus_done), 0);
        tick();
        chk("t1_no_reserve", 64'(mem_req), 0);
        ibus_fetch = 0;
        tick();
        chk("t1_idle", 64'(mem_req), 0);
        chk("t1_hold", 64'(ibus_input), 64'h123456789ABC);

        // 3: simultaneous requests, dbus first, then ibus after recovery
        n_burst = 0; n_ddone = 0; n_idone = 0;
        ibus_fetch = 1; ibus_addr = 15'h0020;
        dbus_read = 1; dbus_addr = 15'h0030;
        tick();
        chk("t3_dbus_first", 64'(mem_addr), 64'h30);
        chk("t3_we", 64'(mem_we), 0);
        mem_ack = 1; mem_rdata = 48'hA5A5_0000_1111;
        tick();
        mem_ack = 0;
        chk("t3_ddone", 64'(dbus_done), 1);
        chk("t3_idone_no", 64'(ibus_done), 0);
        chk("t3_din", 64'(dbus_input), 64'hA5A5_0000_1111);
        tick();
        chk("t3_gap", 64'(mem_req), 0);
        tick();
        chk("t3_ibus_req", 64'(mem_req), 1);
        chk("t3_ibus_addr", 64'(mem_addr), 64'h20);
        dbus_read = 0;
        mem_ack = 1; mem_rdata = 48'h0000_CAFE_0001;
        tick();
        mem_ack = 0;
        chk("t3_idone", 64'(ibus_done), 1);
        chk("t3_iin", 64'(ibus_input), 64'h0000_CAFE_0001);
        tick(); tick();
        chk("t3_no_reserve", 64'(mem_req), 0);
        ibus_fetch = 0;
        tick();
        chk("t3_bursts", 64'(n_burst), 2);
        chk("t3_ddone_cnt", 64'(n_ddone), 1);
        chk("t3_idone_cnt", 64'(n_idone), 1);

        // 2: write with ack in 4th request cycle (last cycle before timeout)
        n_ddone = 0; cyc_cnt = 0;
        dbus_write = 1; dbus_addr = 15'h7FFF; dbus_output = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req && mem_we) cyc_cnt++;
            if (i == 0) begin
                chk("t2_addr", 64'(mem_addr), 64'h7FFF);
                chk("t2_wdata", 64'(mem_wdata), 64'hFFFF_FFFF_FFFF);
            end
            if (i == 3) begin
                mem_ack = 1; mem_rdata = 48'h1111_2222_3333;
            end
        end
        tick();
        mem_ack = 0;
        chk("t2_we_cycles", 64'(cyc_cnt), 4);
        chk("t2_done", 64'(dbus_done), 1);
        chk("t2_we_drop", 64'(mem_we), 0);
        chk("t2_din_kept", 64'(dbus_input), 64'hA5A5_0000_1111);
        chk("t2_no_err", 64'(bus_err), 0);
        tick(); tick();
        dbus_write = 0;
        tick();
        chk("t2_done_cnt", 64'(n_ddone), 1);

        // 6: read and write together -> write plus bus_err
        dbus_read = 1; dbus_write = 1; dbus_addr = 15'h0055; dbus_output = 48'h0000_1234_5678;
        tick();
        chk("t6_we", 64'(mem_we), 1);
        chk("t6_wdata", 64'(mem_wdata), 64'h0000_1234_5678);
        mem_ack = 1; mem_rdata = 48'hDEAD;
        tick();
        mem_ack = 0;
        chk("t6_done", 64'(dbus_done), 1);
        chk("t6_err", 64'(bus_err), 1);
        chk("t6_din_kept", 64'(dbus_input), 64'hA5A5_0000_1111);
        tick(); tick();
        dbus_read = 0; dbus_write = 0;
        tick();

        reset = 1; tick(); tick();
        chk("rst2_err", 64'(bus_err), 0);
        chk("rst2_din", 64'(dbus_input), 0);
        reset = 0; tick();

        // 4: timeout, preceded by a read so dbus_input is nonzero
        dbus_read = 1; dbus_addr = 15'h0044;
        tick();
        mem_ack = 1; mem_rdata = 48'h0F0F_0F0F_0F0F;
        tick();
        mem_ack = 0;
        chk("t4_pre_din", 64'(dbus_input), 64'h0F0F_0F0F_0F0F);
        tick(); tick();
        dbus_read = 0;
        tick();
        n_ddone = 0; cyc_cnt = 0;
        dbus_read = 1; dbus_addr = 15'h0045;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req) cyc_cnt++;
        end
        tick();
        chk("t4_req_cycles", 64'(cyc_cnt), 4);
        chk("t4_req_drop", 64'(mem_req), 0);
        chk("t4_done", 64'(dbus_done), 1);
        chk("t4_din_zero", 64'(dbus_input), 0);
        chk("t4_err", 64'(bus_err), 1);
        tick(); tick();
        dbus_read = 0;
        tick(); tick(); tick();
        chk("t4_err_sticky", 64'(bus_err), 1);
        chk("t4_done_cnt", 64'(n_ddone), 1);

        // 5: reset in ACCESS
        ibus_fetch = 1; ibus_addr = 15'h0077;
        tick();
        chk("t5_req", 64'(mem_req), 1);
        reset = 1; ibus_fetch = 0;
        n_idone = 0;
        tick();
        chk("t5_req_off", 64'(mem_req), 0);
        chk("t5_no_done", 64'(ibus_done), 0);
        chk("t5_addr", 64'(mem_addr), 0);
        chk("t5_err", 64'(bus_err), 0);
        reset = 0;
        tick(); tick(); tick();
        chk("t5_idle", 64'(mem_req), 0);
        chk("t5_done_cnt", 64'(n_idone), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
